// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, types and FSM states for the multi-port register file.
package regfile_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT = $clog2(NREGS_DEFAULT);
    typedef logic [XLEN_DEFAULT-1:0] word_t;
    typedef logic [AW_DEFAULT-1:0] reg_addr_t;
    typedef enum logic {INIT, RUN} rf_state_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits; alloc beats a same-cycle writeback clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD = 2,
    parameter int NWR = 1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic [NRD-1:0]    fwd,
    output logic [NRD-1:0]    rd_busy
);
    logic [NREGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (en) begin
            for (int j = 0; j < NWR; j++)
                if (wr_en[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            if (alloc_en) busy_d[alloc_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
        if (rst) busy_d = '0;
    end

    always_ff @(posedge clk) busy_q <= busy_d;

    // A forwarded write means the value is already available to the reader.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NRD; k++)
            rd_busy[k] = en && !fwd[k] && busy_q[rd_addr[k*AW +: AW]];
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hardwired to zero, optional write bypass,
// busy scoreboard and a sequenced clear after reset so storage can map onto RAM.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD = 2,
    parameter int NWR = 1,
    parameter bit BYPASS = 1'b1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr
);
    rf_state_e state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [XLEN-1:0] mem_q [NREGS];
    logic [NWR-1:0] we;
    logic [NWR*AW-1:0] wa;
    logic [NWR*XLEN-1:0] wd;
    logic [NRD-1:0] fwd;
    logic run;

    assign run = state_q == RUN;
    assign ready = run;

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        if (!run) begin
            idx_d = idx_q + 1'b1;
            state_d = idx_q == AW'(NREGS - 1) ? RUN : INIT;
        end
        if (rst) begin
            state_d = INIT;
            idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        idx_q <= idx_d;
    end

    // During INIT port 0 is borrowed by the clear sequencer; user writes are dropped.
    always_comb begin
        we = '0;
        wa = wr_addr;
        wd = wr_data;
        for (int j = 0; j < NWR; j++)
            we[j] = run && wr_en[j] && wr_addr[j*AW +: AW] != '0;
        if (!run) begin
            we[0] = 1'b1;
            wa[AW-1:0] = idx_q;
            wd[XLEN-1:0] = '0;
        end
    end

    always_ff @(posedge clk)
        for (int j = 0; j < NWR; j++)
            if (we[j]) mem_q[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];

    always_comb begin
        rd_data = '0;
        fwd = '0;
        for (int k = 0; k < NRD; k++)
            if (run && rd_addr[k*AW +: AW] != '0) begin
                rd_data[k*XLEN +: XLEN] = mem_q[rd_addr[k*AW +: AW]];
                for (int j = 0; j < NWR; j++)
                    if (BYPASS && we[j] && wa[j*AW +: AW] == rd_addr[k*AW +: AW]) begin
                        fwd[k] = 1'b1;
                        rd_data[k*XLEN +: XLEN] = wd[j*XLEN +: XLEN];
                    end
            end
    end

    regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD), .NWR(NWR)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .en        (run),
        .wr_en     (we),
        .wr_addr   (wa),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .rd_addr   (rd_addr),
        .fwd       (fwd),
        .rd_busy   (rd_busy)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: bypass and non-bypass instances share stimulus; a queue of predicted
// outputs from an array-based model is drained and compared by a negedge monitor.
module tb_regfile_mp;
    localparam int XL = 32;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [NRD*AW-1:0] rd_addr;
    logic [NWR-1:0] wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*XL-1:0] wr_data;
    logic alloc_en;
    logic [AW-1:0] alloc_addr;
    logic ready_a, ready_b;
    logic [NRD*XL-1:0] rd_data_a, rd_data_b;
    logic [NRD-1:0] rd_busy_a, rd_busy_b;

    regfile_mp #(.XLEN(XL), .NREGS(NR), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .ready(ready_a), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr)
    );

    regfile_mp #(.XLEN(XL), .NREGS(NR), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr)
    );

    typedef struct packed {
        logic ready;
        logic [NRD*XL-1:0] da;
        logic [NRD*XL-1:0] db;
        logic [NRD-1:0] ba;
        logic [NRD-1:0] bb;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int checks = 0;
    int fails = 0;
    int n;

    logic [XL-1:0] m_mem [NR];
    bit m_busy [NR];
    bit m_ready;
    int m_cnt;

    function automatic void chk(string name, logic [XL-1:0] act, logic [XL-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Last matching write port is the one that lands, so it is also the one forwarded.
    function automatic exp_t predict();
        exp_t e;
        e = '0;
        e.ready = m_ready;
        for (int k = 0; k < NRD; k++) begin
            int a;
            int w;
            a = int'(rd_addr[k*AW +: AW]);
            w = -1;
            if (m_ready && a != 0) begin
                for (int j = 0; j < NWR; j++)
                    if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) w = j;
                e.db[k*XL +: XL] = m_mem[a];
                e.bb[k] = m_busy[a];
                e.da[k*XL +: XL] = (w >= 0) ? wr_data[w*XL +: XL] : m_mem[a];
                e.ba[k] = (w < 0) && m_busy[a];
            end
        end
        return e;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_ready = 0;
            m_cnt = 0;
            foreach (m_mem[i]) m_mem[i] = '0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else if (!m_ready) begin
            m_cnt++;
            m_ready = (m_cnt == NR);
        end else begin
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
                    m_mem[wr_addr[j*AW +: AW]] = wr_data[j*XL +: XL];
                    m_busy[wr_addr[j*AW +: AW]] = 0;
                end
            if (alloc_en && alloc_addr != '0) m_busy[alloc_addr] = 1;
        end
    endtask

    task automatic cyc();
        q.push_back(predict());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(int ra0, int ra1, logic [1:0] we, int wa0, logic [XL-1:0] wd0,
                         int wa1, logic [XL-1:0] wd1, logic al, int aa);
        rd_addr = {AW'(ra1), AW'(ra0)};
        wr_en = we;
        wr_addr = {AW'(wa1), AW'(wa0)};
        wr_data = {wd1, wd0};
        alloc_en = al;
        alloc_addr = AW'(aa);
    endtask

    always @(negedge clk)
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("ready_a", 32'(ready_a), 32'(mon_e.ready));
            chk("ready_b", 32'(ready_b), 32'(mon_e.ready));
            for (int k = 0; k < NRD; k++) begin
                chk($sformatf("rd_data_a[%0d]", k), rd_data_a[k*XL +: XL], mon_e.da[k*XL +: XL]);
                chk($sformatf("rd_data_b[%0d]", k), rd_data_b[k*XL +: XL], mon_e.db[k*XL +: XL]);
                chk($sformatf("rd_busy_a[%0d]", k), 32'(rd_busy_a[k]), 32'(mon_e.ba[k]));
                chk($sformatf("rd_busy_b[%0d]", k), 32'(rd_busy_b[k]), 32'(mon_e.bb[k]));
            end
        end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        @(posedge clk);
        model_edge();
        #1;
        cyc();
        cyc();
        // INIT: reads of x5/x31 stay 0, write+alloc to x5 must be ignored
        rst = 1'b0;
        drive(5, 31, 2'b01, 5, 32'h1234_5678, 0, 0, 1'b1, 5);
        n = 0;
        while (!ready_a && n < 100) begin
            cyc();
            n++;
        end
        chk("init_cycles", 32'(n), 32'd32);
        drive(5, 31, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        cyc();
        // bypass vs. non-bypass on x7
        drive(7, 0, 2'b01, 7, 32'hDEAD_BEEF, 0, 0, 1'b0, 0);
        cyc();
        drive(7, 7, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        cyc();
        // x0 is hardwired zero and never busy
        drive(0, 0, 2'b01, 0, 32'hFFFF_FFFF, 0, 0, 1'b1, 0);
        cyc();
        drive(0, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        cyc();
        // two ports writing x3: port 1 wins
        drive(3, 3, 2'b11, 3, 32'h11, 3, 32'h22, 1'b0, 0);
        cyc();
        drive(3, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        cyc();
        // scoreboard on x9
        drive(9, 9, 2'b00, 0, 0, 0, 0, 1'b1, 9);
        cyc();
        drive(9, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        cyc();
        drive(9, 0, 2'b01, 9, 32'h5, 0, 0, 1'b1, 9);
        cyc();
        drive(9, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        cyc();
        drive(9, 0, 2'b01, 9, 32'h5, 0, 0, 1'b0, 0);
        cyc();
        drive(9, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        cyc();
        // random traffic over a narrow address range to provoke collisions
        repeat (400) begin
            drive($urandom_range(0, 15), $urandom_range(0, 15), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 15), $urandom, $urandom_range(0, 15), $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 15));
            cyc();
        end
        // mid-operation reset
        drive(4, 0, 2'b01, 4, 32'hA5, 0, 0, 1'b1, 4);
        cyc();
        drive(4, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n = 0;
        while (!ready_a && n < 100) begin
            cyc();
            n++;
        end
        chk("reinit_cycles", 32'(n), 32'd32);
        cyc();
        cyc();
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the next-generation core.
- Configurable read/write port counts, data width and depth.
- Optional write-to-read bypass.
- Per-register busy scoreboard for multi-cycle and out-of-order writeback.
- Sequenced clear-on-reset, so storage maps to RAM instead of a flop array with parallel reset.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >= 2)
NRD, 2, number of read ports
NWR, 1, number of write ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
AW, $clog2(NREGS), address width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
ready  out  1  high when initialisation is complete and the file accepts traffic
rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
rd_busy  out  NRD  scoreboard busy bit for each read address
wr_en  in  NWR  write enables
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
alloc_en  in  1  mark a destination busy (issue of a multi-cycle producer)
alloc_addr  in  AW  register to mark busy

Behaviour:
- Reset is synchronous, active-high, on clk. While rst=1:
  - ready=0.
  - FSM is held in INIT with clear index = 0.
  - Busy bits are all cleared.
- FSM states:
  - INIT: each cycle writes 0 to reg[idx], then idx++. When idx = NREGS-1, next state is RUN.
  - RUN: ready=1. Stays in RUN until rst.
- Init timing: ready rises exactly NREGS cycles after the first clock edge with rst=0.
- rst asserted mid-INIT or in RUN: the next edge returns to INIT with idx=0 and clears busy bits. Storage contents are undefined until the new INIT completes.
- During INIT:
  - wr_en and alloc_en are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- Register 0 is hardwired zero:
  - Writes to it are dropped.
  - It reads as 0 and is never busy; alloc to 0 is ignored.
- Writes: on a clk edge in RUN, reg[wr_addr[j]] <= wr_data[j] for every j with wr_en[j]=1.
  - If two ports target the same address, the highest j wins.
- Reads are combinational. rd_data[k] = reg[rd_addr[k]], or 0 if the address is 0.
- Bypass, when BYPASS=1: if any active write port targets rd_addr[k] (nonzero), rd_data[k] is that port's wr_data, using the highest j on conflict.
  - When BYPASS=0, a read returns the old value until the next cycle.
- Scoreboard:
  - alloc_en sets busy[alloc_addr] at the edge.
  - An active write clears busy[wr_addr[j]] at the edge.
  - Alloc and write to the same address in the same cycle: alloc wins, so the bit stays busy (new producer).
- rd_busy[k] = busy[rd_addr[k]].
  - With BYPASS=1, rd_busy is forced 0 when a same-cycle write to that address is being forwarded.
- Width: no arithmetic on data. Addresses are AW bits and therefore cannot exceed NREGS-1.

Decomposition:
- Shared package regfile_pkg holds:
  - localparam XLEN_DEFAULT = 32, NREGS_DEFAULT = 32.
  - typedef logic [XLEN-1:0] word_t.
  - typedef logic [AW-1:0] reg_addr_t.
  - enum {INIT, RUN} rf_state_e.
- One sub-module: regfile_scoreboard. It holds the busy vector with its set/clear priority and the busy lookup per read port.
- Storage, bypass muxing and the init FSM stay in regfile_mp.

Test Plan:
- Init: rst=1 for 3 cycles, then 0. ready rises on exactly cycle 32 (NREGS=32); reads of x5 and x31 return 0 throughout INIT; wr_en=1 to x5 during INIT has no effect (x5 reads 0 after ready).
- Write/read with bypass: BYPASS=1, write x7 = 0xDEADBEEF and read x7 in the same cycle, so rd_data = 0xDEADBEEF. Rebuild with BYPASS=0: the same cycle gives the old value 0, and the next cycle gives 0xDEADBEEF.
- Zero register: write x0 = 0xFFFFFFFF with alloc x0, then read. rd_data = 0 and rd_busy = 0.
- Multi-write conflict: NWR=2, both ports write x3 (port0 = 0x11, port1 = 0x22). x3 reads 0x22; bypass also yields 0x22.
- Scoreboard: alloc x9, then rd_busy = 1 on the next cycle. A later write of x9 = 0x5 with an alloc of x9 in the same cycle leaves it busy. A write with no alloc clears busy, and x9 reads 0x5.
- Mid-operation reset: write x4 = 0xA5, pulse rst for 1 cycle in RUN. ready drops, busy clears, and after 32 cycles x4 reads 0.
